// File: rtl/dual_port_ram_be_sync.sv
// Dual-port synchronous RAM: port A read/write with byte enables, port B read-only,
// write-first A->B bypass, self-clearing after reset. Define RAM_OUTPUT_REG_EN for 2-cycle reads.
module dual_port_ram_be_sync #(
    parameter int unsigned            ADDR_WIDTH = 6,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            BYTE_WIDTH = 8,
    parameter logic [BYTE_WIDTH-1:0]  INIT_VALUE = '0,
    localparam int unsigned           NBYTES     = DATA_WIDTH / BYTE_WIDTH,
    localparam int unsigned           DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [NBYTES-1:0]     a_be,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_dout
);

    localparam logic [DATA_WIDTH-1:0] INIT_WORD = {NBYTES{INIT_VALUE}};
    localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a_merged;
    logic                  a_wr, a_rd, b_rd;
    logic                  a_rvalid_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0] a_dout_q, b_dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = ST_IDLE;
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == ST_INIT);
    assign a_wr      = a_req && !init_busy && a_we;
    assign a_rd      = a_req && !init_busy && !a_we;
    assign b_rd      = b_req && !init_busy;

    // Post-write view of the A word, used for the write-first bypass to port B.
    always_comb begin
        a_merged = mem[a_addr];
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (a_be[i]) a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // NOTE: the array has no reset; the clear engine initialises it instead, keeping it mappable to block RAM.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_WORD;
        end else if (a_wr) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (a_be[i]) mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
        end else begin
            a_rvalid_q <= a_rd;
            b_rvalid_q <= b_rd;
            if (a_rd) a_dout_q <= mem[a_addr];
            if (b_rd) b_dout_q <= (a_wr && (a_addr == b_addr)) ? a_merged : mem[b_addr];
        end
    end

`ifdef RAM_OUTPUT_REG_EN
    logic                  a_rvalid_q2, b_rvalid_q2;
    logic [DATA_WIDTH-1:0] a_dout_q2, b_dout_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid_q2 <= 1'b0;
            b_rvalid_q2 <= 1'b0;
            a_dout_q2   <= '0;
            b_dout_q2   <= '0;
        end else begin
            a_rvalid_q2 <= a_rvalid_q;
            b_rvalid_q2 <= b_rvalid_q;
            if (a_rvalid_q) a_dout_q2 <= a_dout_q;
            if (b_rvalid_q) b_dout_q2 <= b_dout_q;
        end
    end

    assign a_rvalid = a_rvalid_q2;
    assign a_dout   = a_dout_q2;
    assign b_rvalid = b_rvalid_q2;
    assign b_dout   = b_dout_q2;
`else
    assign a_rvalid = a_rvalid_q;
    assign a_dout   = a_dout_q;
    assign b_rvalid = b_rvalid_q;
    assign b_dout   = b_dout_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_be_sync.sv
// Self-checking bench for dual_port_ram_be_sync: directed scenarios plus random traffic
// compared cycle by cycle against a word-array reference model with a read-latency delay line.
module tb_dual_port_ram_be_sync;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NB    = 4;
`ifdef RAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] INIT_WORD = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_busy;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [NB-1:0] a_be = '0;
    logic [AW-1:0] a_addr = '0;
    logic [31:0]   a_din = '0;
    logic          a_rvalid;
    logic [31:0]   a_dout;
    logic          b_req = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic          b_rvalid;
    logic [31:0]   b_dout;

    dual_port_ram_be_sync #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .BYTE_WIDTH(8), .INIT_VALUE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_rvalid(a_rvalid), .a_dout(a_dout),
        .b_req(b_req), .b_addr(b_addr), .b_rvalid(b_rvalid), .b_dout(b_dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: memory contents, remaining clear cycles, expected-read delay lines.
    logic [31:0] model [DEPTH];
    int          busy_left;
    bit          pa_v [LAT];
    bit          pb_v [LAT];
    logic [31:0] pa_d [LAT];
    logic [31:0] pb_d [LAT];
    logic [31:0] last_a, last_b;
    int          a_rv_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict what this edge accepts, advance, then compare every output.
    task automatic step();
        bit          acc, av, bv;
        logic [31:0] ad, bd, mask;
        acc = (busy_left == 0);
        av  = acc && a_req && !a_we;
        ad  = model[a_addr];
        if (acc && a_req && a_we) begin
            for (int i = 0; i < NB; i++) begin
                mask = 32'hFF << (8 * i);
                if (a_be[i]) model[a_addr] = (model[a_addr] & ~mask) | (a_din & mask);
            end
        end
        bv = acc && b_req;
        bd = model[b_addr];
        @(posedge clk);
        #1;
        if (busy_left > 0) busy_left--;
        for (int i = LAT - 1; i > 0; i--) begin
            pa_v[i] = pa_v[i-1]; pa_d[i] = pa_d[i-1];
            pb_v[i] = pb_v[i-1]; pb_d[i] = pb_d[i-1];
        end
        pa_v[0] = av; pa_d[0] = ad;
        pb_v[0] = bv; pb_d[0] = bd;
        if (pa_v[LAT-1]) last_a = pa_d[LAT-1];
        if (pb_v[LAT-1]) last_b = pb_d[LAT-1];
        check("init_busy", init_busy, busy_left != 0);
        check("a_rvalid", a_rvalid, pa_v[LAT-1]);
        check("a_dout", a_dout, last_a);
        check("b_rvalid", b_rvalid, pb_v[LAT-1]);
        check("b_dout", b_dout, last_b);
        if (a_rvalid) a_rv_seen++;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) model[i] = INIT_WORD;
        for (int i = 0; i < LAT; i++) begin
            pa_v[i] = 1'b0; pb_v[i] = 1'b0; pa_d[i] = '0; pb_d[i] = '0;
        end
        last_a    = '0;
        last_b    = '0;
        busy_left = DEPTH;
        check("rst_busy", init_busy, 1);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_a_dout", a_dout, 0);
        check("rst_b_dout", b_dout, 0);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic a_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [NB-1:0] be);
        a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_din = data; a_be = be;
        step();
        a_req = 1'b0; a_we = 1'b0;
    endtask

    task automatic a_read(input logic [AW-1:0] addr);
        a_req = 1'b1; a_we = 1'b0; a_addr = addr;
        step();
        a_req = 1'b0;
        repeat (LAT - 1) step();
    endtask

    task automatic b_read(input logic [AW-1:0] addr);
        b_req = 1'b1; b_addr = addr;
        step();
        b_req = 1'b0;
        repeat (LAT - 1) step();
    endtask

    // Counts clear cycles while stepping; bounded in case init_busy never drops.
    task automatic count_clear(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        apply_reset(3);

        // Clear engine with requests hammering both ports; none may take effect.
        a_req = 1'b1; a_addr = 4'd2; a_din = 32'hFFFFFFFF; a_be = 4'hF;
        b_req = 1'b1; b_addr = 4'd2;
        a_rv_seen = 0;
        n = 0;
        while (init_busy === 1'b1 && n < 200) begin
            a_we = ~n[0];
            step();
            n++;
        end
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
        check("clear_len", n, DEPTH);
        check("no_rvalid_in_init", a_rv_seen, 0);

        for (int i = 0; i < DEPTH; i++) begin
            b_read(AW'(i));
            check("clear_rd_valid", b_rvalid, 1);
            check("clear_rd_data", b_dout, INIT_WORD);
        end
        a_read(4'd2);
        check("ignored_wr_addr2", a_dout, INIT_WORD);

        // Byte-enable merge.
        a_write(4'd3, 32'h11223344, 4'hF);
        a_write(4'd3, 32'hAABBCCDD, 4'b0101);
        a_read(4'd3);
        check("be_merge", a_dout, 32'h11BB33DD);

        // Write-first collision.
        a_write(4'd7, 32'h0, 4'hF);
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_din = 32'hDEADBEEF; a_be = 4'b1100;
        b_req = 1'b1; b_addr = 4'd7;
        step();
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
        repeat (LAT - 1) step();
        check("collide_valid", b_rvalid, 1);
        check("collide_data", b_dout, 32'hDEAD0000);

        // Write followed immediately by a read of the same word.
        a_write(4'd9, 32'h0BADF00D, 4'hF);
        a_read(4'd9);
        check("wr_then_rd", a_dout, 32'h0BADF00D);

        // Streaming reads.
        for (int i = 0; i < 8; i++) a_write(AW'(i), 32'(i), 4'hF);
        a_rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = AW'(i);
            step();
        end
        a_req = 1'b0;
        repeat (LAT) step();
        check("stream_rvalid_cnt", a_rv_seen, 8);
        check("stream_last", a_dout, 32'd7);

        // Random traffic, addresses biased to a small window to force collisions.
        for (int c = 0; c < 400; c++) begin
            a_req  = ($urandom % 4) != 0;
            a_we   = $urandom % 2;
            a_be   = NB'($urandom);
            a_din  = $urandom;
            a_addr = ($urandom % 2) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
            b_req  = ($urandom % 4) != 0;
            b_addr = ($urandom % 2) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
            step();
        end
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0;
        repeat (LAT) step();

        // Reset with a B read in flight: rvalid must drop at once and the clear restarts.
        b_req = 1'b1; b_addr = 4'd5;
        step();
        b_req = 1'b0;
        repeat (LAT - 1) step();
        check("inflight_valid", b_rvalid, 1);
        apply_reset(2);
        count_clear(n);
        check("clear_len_idle_rst", n, DEPTH);
        a_read(4'd3);
        check("recleared", a_dout, INIT_WORD);

        // Reset asserted on cycle 5 of the clear, held 2 cycles, B request pending.
        apply_reset(1);
        b_req = 1'b1; b_addr = 4'd1;
        repeat (4) step();
        apply_reset(2);
        check("midclear_b_rvalid", b_rvalid, 0);
        count_clear(n);
        b_req = 1'b0;
        check("clear_len_mid_rst", n, DEPTH);
        repeat (LAT) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
